// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, addresses instruction memory and registers
// each fetched word (tagged when it is the immediate half of a long instruction).
module fetch_stage #(
   parameter int unsigned     PC_W     = 16,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter logic [15:0]     NOP_WORD = 16'h0000
) (
   input  logic            Clk,
   input  logic            Rst,
   input  logic            Stall,
   input  logic            Branch_Taken,
   input  logic [PC_W-1:0] Branch_Target,
   output logic [PC_W-1:0] Imem_Addr,
   input  logic [15:0]     Imem_Data,
   output logic [15:0]     Out,
   output logic [PC_W-1:0] Out_PC,
   output logic            Out_Valid,
   output logic            Out_Imm_Word
);

   typedef enum logic {
      FIRST  = 1'b0,
      SECOND = 1'b1
   } state_t;

   state_t          state, state_nxt;
   logic [PC_W-1:0] pc_p0, pc_nxt;
   logic [15:0]     word_p1, word_nxt;
   logic [PC_W-1:0] word_pc_p1, word_pc_nxt;
   logic            vld_p1, vld_nxt;
   logic            imm_p1, imm_nxt;
   logic            advance;
   logic            long_form;

   function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
      return pc + {{(PC_W-1){1'b0}}, 1'b1};
   endfunction

   assign advance   = !Stall && !Branch_Taken;
   assign long_form = (Imem_Data[15:13] == 3'b111);

   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc_p0;
      word_nxt    = word_p1;
      word_pc_nxt = word_pc_p1;
      vld_nxt     = vld_p1;
      imm_nxt     = imm_p1;
      if (Branch_Taken) begin
         // redirect discards the word at the old PC and any pending immediate
         state_nxt = FIRST;
         pc_nxt    = Branch_Target;
         word_nxt  = NOP_WORD;
         vld_nxt   = 1'b0;
         imm_nxt   = 1'b0;
      end else if (advance) begin
         pc_nxt      = pc_inc(pc_p0);
         word_nxt    = Imem_Data;
         word_pc_nxt = pc_p0;
         vld_nxt     = 1'b1;
         imm_nxt     = (state == SECOND);
         case (state)
            FIRST:   state_nxt = long_form ? SECOND : FIRST;
            SECOND:  state_nxt = FIRST;
            default: state_nxt = FIRST;
         endcase
      end
   end

   // p0 -> p1: PC/state update and IF/ID register
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state      <= FIRST;
         pc_p0      <= RESET_PC;
         word_p1    <= NOP_WORD;
         word_pc_p1 <= '0;
         vld_p1     <= 1'b0;
         imm_p1     <= 1'b0;
      end else begin
         state      <= state_nxt;
         pc_p0      <= pc_nxt;
         word_p1    <= word_nxt;
         word_pc_p1 <= word_pc_nxt;
         vld_p1     <= vld_nxt;
         imm_p1     <= imm_nxt;
      end
   end

   assign Imem_Addr    = pc_p0;
   assign Out          = word_p1;
   assign Out_PC       = word_pc_p1;
   assign Out_Valid    = vld_p1;
   assign Out_Imm_Word = imm_p1;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a word-level model checked every cycle, plus
// hand-computed literal checks at the interesting points of each scenario.
module tb_fetch_stage;

   localparam int          PC_W = 16;
   localparam logic [15:0] NOP  = 16'h0000;

   logic            Clk = 1'b0;
   logic            Rst;
   logic            Stall;
   logic            Branch_Taken;
   logic [PC_W-1:0] Branch_Target;
   logic [PC_W-1:0] Imem_Addr;
   logic [15:0]     Imem_Data;
   logic [15:0]     Out;
   logic [PC_W-1:0] Out_PC;
   logic            Out_Valid;
   logic            Out_Imm_Word;

   logic [15:0] imem [0:65535];

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   // model state: what decode should see, and what address fetch should present
   logic [PC_W-1:0] m_pc;
   logic [15:0]     m_out;
   logic [PC_W-1:0] m_out_pc;
   logic            m_valid;
   logic            m_imm;
   int              m_words_owed;  // immediate words still owed to the current long instruction

   fetch_stage #(.PC_W(PC_W), .RESET_PC(16'h0000), .NOP_WORD(NOP)) dut (
      .Clk(Clk), .Rst(Rst), .Stall(Stall), .Branch_Taken(Branch_Taken),
      .Branch_Target(Branch_Target), .Imem_Addr(Imem_Addr), .Imem_Data(Imem_Data),
      .Out(Out), .Out_PC(Out_PC), .Out_Valid(Out_Valid), .Out_Imm_Word(Out_Imm_Word)
   );

   assign Imem_Data = imem[Imem_Addr];

   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge Clk) begin
      if (!Rst) begin
         m_pc = 16'h0000; m_out = NOP; m_out_pc = '0;
         m_valid = 1'b0; m_imm = 1'b0; m_words_owed = 0;
      end else if (Branch_Taken) begin
         m_pc = Branch_Target; m_out = NOP;
         m_valid = 1'b0; m_imm = 1'b0; m_words_owed = 0;
      end else if (!Stall) begin
         m_out    = imem[m_pc];
         m_out_pc = m_pc;
         m_valid  = 1'b1;
         if (m_words_owed > 0) begin
            m_imm = 1'b1;
            m_words_owed = m_words_owed - 1;
         end else begin
            m_imm = 1'b0;
            if (m_out[15:13] == 3'b111) m_words_owed = 1;
         end
         m_pc = m_pc + 16'd1;
      end
   end

   always @(negedge Clk) begin
      if (chk_en) begin
         check("model_imem_addr", 32'(Imem_Addr), 32'(m_pc));
         check("model_out", 32'(Out), 32'(m_out));
         check("model_out_pc", 32'(Out_PC), 32'(m_out_pc));
         check("model_valid", 32'(Out_Valid), 32'(m_valid));
         check("model_imm", 32'(Out_Imm_Word), 32'(m_imm));
      end
   end

   task automatic tick();
      @(negedge Clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) imem[i] = {3'b000, 13'(i)};
      imem[0] = 16'h1111; imem[1] = 16'h2222; imem[2] = 16'h3333; imem[3] = 16'h4444;
      imem[4] = 16'hE123; imem[5] = 16'h00AB; imem[6] = 16'h1000; imem[7] = 16'h7777;
      imem[16'h0040] = 16'h5040; imem[16'hFFFF] = 16'h00FF;

      Rst = 1'b0; Stall = 1'b0; Branch_Taken = 1'b0; Branch_Target = '0;
      tick();
      chk_en = 1'b1;
      check("reset_out", 32'(Out), 32'h0000);
      check("reset_valid", 32'(Out_Valid), 32'h0);
      check("reset_addr", 32'(Imem_Addr), 32'h0000);

      // straight-line fetch
      Rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("seq_imm", 32'(Out_Imm_Word), 32'h0);
      end
      check("seq_out", 32'(Out), 32'h3333);
      check("seq_out_pc", 32'(Out_PC), 32'h0002);
      check("seq_valid", 32'(Out_Valid), 32'h1);

      // long instruction at 4, immediate at 5
      tick(); tick();
      check("long_first_out", 32'(Out), 32'hE123);
      check("long_first_imm", 32'(Out_Imm_Word), 32'h0);
      tick();
      check("long_imm_out", 32'(Out), 32'h00AB);
      check("long_imm_flag", 32'(Out_Imm_Word), 32'h1);
      tick();
      check("after_long_out", 32'(Out), 32'h1000);
      check("after_long_imm", 32'(Out_Imm_Word), 32'h0);

      // stall for three cycles at PC=7
      Stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_addr", 32'(Imem_Addr), 32'h0007);
         check("stall_out", 32'(Out), 32'h1000);
         check("stall_out_pc", 32'(Out_PC), 32'h0006);
      end
      Stall = 1'b0;
      tick();
      check("unstall_out", 32'(Out), 32'h7777);
      check("unstall_out_pc", 32'(Out_PC), 32'h0007);

      // immediate word that looks long-form is still just an immediate
      imem[5] = 16'hE000;
      Branch_Taken = 1'b1; Branch_Target = 16'h0004;
      tick();
      check("br4_valid", 32'(Out_Valid), 32'h0);
      check("br4_addr", 32'(Imem_Addr), 32'h0004);
      Branch_Taken = 1'b0;
      tick(); tick();
      check("e000_out", 32'(Out), 32'hE000);
      check("e000_imm", 32'(Out_Imm_Word), 32'h1);
      tick();
      check("e000_next_out", 32'(Out), 32'h1000);
      check("e000_next_imm", 32'(Out_Imm_Word), 32'h0);

      // redirect while in SECOND, with stall also high
      Branch_Taken = 1'b1; Branch_Target = 16'h0004;
      tick();
      Branch_Taken = 1'b0;
      tick();
      check("pre_abort_out", 32'(Out), 32'hE123);
      Branch_Taken = 1'b1; Stall = 1'b1; Branch_Target = 16'h0040;
      tick();
      check("abort_out", 32'(Out), 32'(NOP));
      check("abort_valid", 32'(Out_Valid), 32'h0);
      check("abort_addr", 32'(Imem_Addr), 32'h0040);
      Branch_Taken = 1'b0; Stall = 1'b0;
      tick();
      check("abort_next_pc", 32'(Out_PC), 32'h0040);
      check("abort_next_imm", 32'(Out_Imm_Word), 32'h0);
      check("abort_next_out", 32'(Out), 32'h5040);

      // back-to-back redirects: the last target wins
      Branch_Taken = 1'b1; Branch_Target = 16'h0030;
      tick();
      Branch_Target = 16'h0060;
      tick();
      Branch_Taken = 1'b0;
      tick();
      check("br2_out_pc", 32'(Out_PC), 32'h0060);

      // PC wrap at all-ones
      Branch_Taken = 1'b1; Branch_Target = 16'hFFFF;
      tick();
      Branch_Taken = 1'b0;
      tick();
      check("wrap_out_pc", 32'(Out_PC), 32'hFFFF);
      check("wrap_out", 32'(Out), 32'h00FF);
      check("wrap_addr", 32'(Imem_Addr), 32'h0000);
      tick();
      check("wrap_next_out_pc", 32'(Out_PC), 32'h0000);

      // reset right after a long-form word, with a branch request also asserted
      Branch_Taken = 1'b1; Branch_Target = 16'h0004;
      tick();
      Branch_Taken = 1'b0;
      tick();
      check("pre_rst_out", 32'(Out), 32'hE123);
      Rst = 1'b0; Branch_Taken = 1'b1; Branch_Target = 16'h0099;
      tick();
      check("rst_out", 32'(Out), 32'(NOP));
      check("rst_valid", 32'(Out_Valid), 32'h0);
      check("rst_imm", 32'(Out_Imm_Word), 32'h0);
      check("rst_out_pc", 32'(Out_PC), 32'h0000);
      check("rst_addr", 32'(Imem_Addr), 32'h0000);
      Rst = 1'b1; Branch_Taken = 1'b0;
      tick();
      check("post_rst_out", 32'(Out), 32'h1111);
      check("post_rst_imm", 32'(Out_Imm_Word), 32'h0);
      tick();

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
